// File: rtl/fault_mon_pkg.sv
// Shared types and constants for the toggle fault monitor.
package fault_mon_pkg;

  localparam int unsigned TS_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MONITOR = 2'd2
  } mon_state_e;

  // Fixed-width part of a fault report; the faulty-bit mask travels next to it
  // in the FIFO word because its width is chosen per instance.
  typedef struct packed {
    logic [TS_W-1:0] ts;
  } fault_rpt_t;

endpackage

// File: rtl/fault_report_fifo.sv
// Synchronous FIFO holding fault reports; DEPTH must be a power of two (>= 2).
module fault_report_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/toggle_fault_monitor.sv
// Checks that enabled toggle registers flip every cycle and disabled ones stay low.
// Define FAULT_MON_TIMESTAMP_EN to timestamp reports; otherwise rpt_ts is tied to 0.
module toggle_fault_monitor
  import fault_mon_pkg::*;
#(
  parameter int unsigned N_REGS     = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REGS-1:0] en_mask,
  input  logic [N_REGS-1:0] obs,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic [N_REGS-1:0] fault_vec,
  output logic [CNT_W-1:0]  fault_count,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [N_REGS-1:0] rpt_bits,
  output logic [TS_W-1:0]   rpt_ts,
  output logic              overflow
);

`ifdef FAULT_MON_TIMESTAMP_EN
  localparam int unsigned RPT_W = N_REGS + TS_W;
`else
  localparam int unsigned RPT_W = N_REGS;
`endif

  mon_state_e        state_q, state_d;
  logic              arm_done_q, arm_done_d;
  logic [N_REGS-1:0] mask_q, mask_d;
  logic [N_REGS-1:0] obs_q, obs_d;
  logic [N_REGS-1:0] obs_p, obs_p_d;
  logic [N_REGS-1:0] fault_vec_q, fault_vec_d;
  logic [CNT_W-1:0]  fault_cnt_q, fault_cnt_d;
  logic              overflow_q, overflow_d;
  logic              start_mon;
  logic [N_REGS-1:0] fault_bits;
  logic              any_fault;
  logic              fifo_full;
  logic              fifo_empty;
  logic [RPT_W-1:0]  push_data;
  logic [RPT_W-1:0]  pop_data;

  always_comb begin
    obs_d   = obs;
    obs_p_d = obs_q;
  end

  always_comb begin
    fault_bits = '0;
    if (state_q == ST_MONITOR) begin
      fault_bits = (mask_q & ~(obs_q ^ obs_p)) | (~mask_q & obs_q);
    end
  end

  assign any_fault = |fault_bits;

  always_comb begin
    state_d     = state_q;
    arm_done_d  = arm_done_q;
    mask_d      = mask_q;
    fault_vec_d = fault_vec_q;
    fault_cnt_d = fault_cnt_q;
    overflow_d  = overflow_q;
    start_mon   = 1'b0;

    // stop is only looked at once armed, so start+stop from IDLE acts as start.
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ARM;
          arm_done_d = 1'b0;
          mask_d     = en_mask;
          start_mon  = 1'b1;
        end
      end
      ST_ARM: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (arm_done_q) begin
          state_d = ST_MONITOR;
        end else begin
          arm_done_d = 1'b1;
        end
      end
      ST_MONITOR: begin
        if (stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_mon) begin
      fault_vec_d = '0;
      fault_cnt_d = '0;
      overflow_d  = 1'b0;
    end else if (any_fault) begin
      fault_vec_d = fault_vec_q | fault_bits;
      if (!(&fault_cnt_q)) fault_cnt_d = fault_cnt_q + CNT_W'(1);
      // A full FIFO only takes the report if the head leaves this same cycle.
      if (fifo_full && !rpt_ready) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      arm_done_q  <= 1'b0;
      mask_q      <= '0;
      obs_q       <= '0;
      obs_p       <= '0;
      fault_vec_q <= '0;
      fault_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_done_q  <= arm_done_d;
      mask_q      <= mask_d;
      obs_q       <= obs_d;
      obs_p       <= obs_p_d;
      fault_vec_q <= fault_vec_d;
      fault_cnt_q <= fault_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef FAULT_MON_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  fault_rpt_t      rpt_in;
  fault_rpt_t      rpt_out;

  always_comb begin
    ts_d = ts_q;
    if (start_mon) begin
      ts_d = '0;
    end else if (state_q == ST_MONITOR) begin
      ts_d = ts_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_d;
  end

  always_comb begin
    rpt_in    = '0;
    rpt_in.ts = ts_q;
    push_data = {rpt_in, fault_bits};
  end

  assign rpt_out = fault_rpt_t'(pop_data[RPT_W-1:N_REGS]);
  assign rpt_ts  = fifo_empty ? '0 : rpt_out.ts;
`else
  assign push_data = fault_bits;
  assign rpt_ts    = '0;
`endif

  fault_report_fifo #(
    .WIDTH (RPT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (start_mon),
    .push      (any_fault),
    .push_data (push_data),
    .pop       (rpt_ready),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign busy        = (state_q != ST_IDLE);
  assign fault_vec   = fault_vec_q;
  assign fault_count = fault_cnt_q;
  assign overflow    = overflow_q;
  assign rpt_valid   = !fifo_empty;
  assign rpt_bits    = fifo_empty ? '0 : pop_data[N_REGS-1:0];

endmodule
